decoder_2x4_seq: RTL and testbench

- Registered, handshaked 2-to-4 one-hot decoder. It is the inverse of the team's 4x2 encoder.
- Code mapping:
  - code 0 -> y=0001
  - code 1 -> y=0010
  - code 2 -> y=0100
  - code 3 -> y=1000
- Each accepted code drives its one-hot line for a programmable number of cycles. A guaranteed all-zero gap cycle follows (break-before-make).
- An auto-scan mode walks all four lines in sequence. Intended for driving select/strobe lines and for closed-loop encoder/decoder checks.

---
 rtl/decoder_2x4_seq.sv | 105 ++++++++++
 tb/tb_decoder_2x4_seq.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/decoder_2x4_seq.sv
// Registered, handshaked 2-to-4 one-hot decoder with programmable hold time,
// a guaranteed zero gap after every pulse, and an auto-scan mode.
module decoder_2x4_seq #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] code,
  input  logic       scan_en,
  output logic [3:0] y,
  output logic       y_valid,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

  // A hold of 0 would never assert the line, so it is promoted to 1.
  localparam int               HOLD_EFF = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(HOLD_EFF - 1);

  state_t           state_q, state_d;
  logic [3:0]       y_q, y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic             scan_q, scan_d;

  function automatic logic [3:0] onehot(input logic [1:0] c);
    return 4'b0001 << c;
  endfunction

  assign in_ready = (state_q == IDLE) && !scan_en;
  assign y        = y_q;
  assign y_valid  = |y_q;
  assign busy     = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    scan_d  = scan_q;
    case (state_q)
      IDLE: begin
        // Scan wins over a simultaneous handshake; the code stays unconsumed.
        if (scan_en) begin
          idx_d   = 2'd0;
          y_d     = 4'b0001;
          cnt_d   = CNT_INIT;
          scan_d  = 1'b1;
          state_d = HOLD;
        end else if (in_valid) begin
          y_d     = onehot(code);
          cnt_d   = CNT_INIT;
          scan_d  = 1'b0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          y_d     = 4'b0000;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP: begin
        // Only a slot started by the scanner may chain straight into the next.
        if (scan_q && scan_en) begin
          idx_d   = idx_q + 2'd1;
          y_d     = onehot(idx_q + 2'd1);
          cnt_d   = CNT_INIT;
          state_d = HOLD;
        end else begin
          scan_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        y_d     = 4'b0000;
        scan_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      y_q     <= 4'b0000;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      scan_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      scan_q  <= scan_d;
    end
  end

endmodule

// File: tb/tb_decoder_2x4_seq.sv
// Directed bench for decoder_2x4_seq: vector table plus hand-written
// sequences for scan, collision, async reset and the zero-hold build.
module tb_decoder_2x4_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0, scan_en = 1'b0;
  logic [1:0] code = 2'd0;
  logic       in_ready, y_valid, busy;
  logic [3:0] y;

  logic       in_valid0 = 1'b0, scan_en0 = 1'b0;
  logic [1:0] code0 = 2'd0;
  logic       in_ready0, y_valid0, busy0;
  logic [3:0] y0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decoder_2x4_seq #(.HOLD_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .code(code), .scan_en(scan_en), .y(y), .y_valid(y_valid), .busy(busy)
  );

  decoder_2x4_seq #(.HOLD_CYCLES(0), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .code(code0), .scan_en(scan_en0), .y(y0), .y_valid(y_valid0), .busy(busy0)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] oh(input int c);
    logic [3:0] one;
    one = 4'b0001;
    return one << c;
  endfunction

  // Reference 4x2 encoder for the closed-loop check.
  function automatic int enc(input logic [3:0] v);
    case (v)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("yv_eq_or_y", int'(y_valid), int'(|y));
      chk("onehot0", int'($onehot0(y)), 1);
    end
  end

  typedef struct {
    logic       v;
    logic [1:0] c;
    logic       rdy;
    logic [3:0] ey;
    logic       eb;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // {valid, code, ready-before-edge, y after edge, busy after edge}
    tbl[0]  = '{1'b1, 2'd2, 1'b1, 4'b0100, 1'b1};
    tbl[1]  = '{1'b0, 2'd0, 1'b0, 4'b0100, 1'b1};
    tbl[2]  = '{1'b0, 2'd0, 1'b0, 4'b0100, 1'b1};
    tbl[3]  = '{1'b0, 2'd0, 1'b0, 4'b0100, 1'b1};
    tbl[4]  = '{1'b0, 2'd0, 1'b0, 4'b0000, 1'b1};
    tbl[5]  = '{1'b0, 2'd0, 1'b0, 4'b0000, 1'b0};
    tbl[6]  = '{1'b1, 2'd3, 1'b1, 4'b1000, 1'b1};
    tbl[7]  = '{1'b1, 2'd0, 1'b0, 4'b1000, 1'b1};
    tbl[8]  = '{1'b1, 2'd1, 1'b0, 4'b1000, 1'b1};
    tbl[9]  = '{1'b0, 2'd0, 1'b0, 4'b1000, 1'b1};
    tbl[10] = '{1'b0, 2'd0, 1'b0, 4'b0000, 1'b1};
    tbl[11] = '{1'b0, 2'd0, 1'b0, 4'b0000, 1'b0};

    // Reset and idle
    repeat (3) step();
    chk("rst_y", int'(y), 0);
    chk("rst_yv", int'(y_valid), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    step();
    chk("idle_y", int'(y), 0);
    chk("idle_busy", int'(busy), 0);
    chk("idle_rdy", int'(in_ready), 1);

    // Zero-hold build: single-cycle pulse then gap then idle
    in_valid0 = 1'b1; code0 = 2'd1;
    step();
    in_valid0 = 1'b0;
    chk("h0_pulse", int'(y0), 4'b0010);
    step();
    chk("h0_gap_y", int'(y0), 0);
    chk("h0_gap_busy", int'(busy0), 1);
    step();
    chk("h0_idle_busy", int'(busy0), 0);

    // Vector table: single decode and code sampling
    for (int i = 0; i < 12; i++) begin
      in_valid = tbl[i].v;
      code     = tbl[i].c;
      #1;
      chk($sformatf("tbl%0d_rdy", i), int'(in_ready), int'(tbl[i].rdy));
      step();
      chk($sformatf("tbl%0d_y", i), int'(y), int'(tbl[i].ey));
      chk($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].eb));
    end

    // Back-to-back with in_valid held, closed loop through encoder
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      code = 2'(i);
      n = 0;
      while (!in_ready && n < 20) begin
        step();
        n++;
      end
      chk($sformatf("b2b%0d_wait", i), int'(n < 20), 1);
      step();
      if (i == 3) in_valid = 1'b0;
      chk($sformatf("b2b%0d_loop", i), enc(y), i);
      repeat (3) begin
        step();
        chk($sformatf("b2b%0d_hold", i), int'(y), int'(oh(i)));
      end
      step();
      chk($sformatf("b2b%0d_gap", i), int'(y), 0);
    end
    step();
    chk("b2b_idle", int'(busy), 0);

    // Scan with wrap; collision on entry (code 3 must not be consumed)
    in_valid = 1'b1; code = 2'd3; scan_en = 1'b1;
    #1;
    chk("coll_rdy", int'(in_ready), 0);
    for (int t = 0; t < 26; t++) begin
      step();
      chk($sformatf("scan%0d_y", t), int'(y),
          (t < 25 && (t % 5) < 4) ? int'(oh((t / 5) % 4)) : 0);
      chk($sformatf("scan%0d_busy", t), int'(busy), int'(t < 25));
      if (t == 21) begin
        scan_en  = 1'b0;
        in_valid = 1'b0;
      end
    end

    // Re-entering scan restarts at index 0
    scan_en = 1'b1;
    step();
    chk("rescan_y", int'(y), 4'b0001);
    scan_en = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      step();
      n++;
    end
    chk("rescan_done", int'(busy), 0);

    // Async reset mid-HOLD
    in_valid = 1'b1; code = 2'd3;
    step();
    in_valid = 1'b0;
    chk("ar_pulse", int'(y), 4'b1000);
    step();
    #3 rst_n = 1'b0;
    #1;
    chk("ar_y", int'(y), 0);
    chk("ar_yv", int'(y_valid), 0);
    chk("ar_busy", int'(busy), 0);
    step();
    step();
    rst_n = 1'b1;
    repeat (6) begin
      step();
      chk("ar_after_y", int'(y), 0);
      chk("ar_after_busy", int'(busy), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
